// File: rtl/stove_button_conditioner.sv
// stove_button_conditioner
//   Conditions five raw push-button/switch lines into clean one-clock command
//   pulses for the stove controller. Each channel has a 2-FF synchroniser, a
//   debounce FSM (RELEASED / PRESS_DB / PRESSED / RELEASE_DB) and a press-edge
//   pulse. Increment/decrement pulses that would land in the same cycle
//   cancel each other.
//
//   Optional feature macro: STOVE_BTN_AUTOREPEAT_EN
//     defined   -> inc/dec channels auto-repeat while held
//     undefined -> every channel pulses once per accepted press
//
// Ports
//   clk              in   system clock
//   async_reset      in   asynchronous active-low reset
//   btn_raw[4:0]     in   raw lines: [0] power, [1] surface A, [2] surface B,
//                         [3] inc, [4] dec
//   power_toggle     out  one-clock pulse per accepted power press
//   surface_toggle   out  [0] A, [1] B one-clock pulses
//   power_level_inc  out  one-clock pulse on press (and repeats)
//   power_level_dec  out  one-clock pulse on press (and repeats)
//   btn_level[4:0]   out  debounced pressed level per channel, active-high
module stove_button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES   = 500000,
  parameter int unsigned REPEAT_DELAY      = 25000000,
  parameter int unsigned REPEAT_PERIOD     = 10000000,
  parameter int unsigned BUTTON_ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       async_reset,
  input  logic [4:0] btn_raw,
  output logic       power_toggle,
  output logic [1:0] surface_toggle,
  output logic       power_level_inc,
  output logic       power_level_dec,
  output logic [4:0] btn_level
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Synchronisers reset to the raw "released" level of the button polarity.
  localparam logic [4:0] RAW_RELEASED = (BUTTON_ACTIVE_LOW != 0) ? '1 : '0;

  typedef enum logic [1:0] {
    RELEASED   = 2'd0,
    PRESS_DB   = 2'd1,
    PRESSED    = 2'd2,
    RELEASE_DB = 2'd3
  } state_e;

  logic [4:0] sync1_q, sync2_q;
  logic [4:0] act;
  logic [4:0] pulse;

  always_ff @(posedge clk or negedge async_reset) begin
    if (!async_reset) begin
      sync1_q <= RAW_RELEASED;
      sync2_q <= RAW_RELEASED;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  assign act = (BUTTON_ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;

  for (genvar i = 0; i < 5; i++) begin : g_ch
    state_e        st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          lvl_q, lvl_d;
    logic          db_fire;
    logic          rep_fire;

    always_comb begin
      st_d    = st_q;
      cnt_d   = cnt_q;
      lvl_d   = lvl_q;
      db_fire = 1'b0;
      unique case (st_q)
        RELEASED: begin
          if (act[i]) begin
            st_d  = PRESS_DB;
            cnt_d = '0;
          end
        end
        PRESS_DB: begin
          if (!act[i]) begin
            st_d  = RELEASED;
            cnt_d = '0;
          end else if (cnt_q == DB_LAST) begin
            st_d    = PRESSED;
            cnt_d   = '0;
            lvl_d   = 1'b1;
            db_fire = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        PRESSED: begin
          if (!act[i]) begin
            st_d  = RELEASE_DB;
            cnt_d = '0;
          end
        end
        RELEASE_DB: begin
          if (act[i]) begin
            st_d  = PRESSED;
            cnt_d = '0;
          end else if (cnt_q == DB_LAST) begin
            st_d  = RELEASED;
            cnt_d = '0;
            lvl_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          st_d  = RELEASED;
          cnt_d = '0;
          lvl_d = 1'b0;
        end
      endcase
    end

    always_ff @(posedge clk or negedge async_reset) begin
      if (!async_reset) begin
        st_q  <= RELEASED;
        cnt_q <= '0;
        lvl_q <= 1'b0;
      end else begin
        st_q  <= st_d;
        cnt_q <= cnt_d;
        lvl_q <= lvl_d;
      end
    end

`ifdef STOVE_BTN_AUTOREPEAT_EN
    if (i >= 3) begin : g_rep
      localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
      localparam int unsigned RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
      localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
      localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

      logic [RW-1:0] rep_q, rep_d;
      logic          ph_q, ph_d;   // 0: waiting initial delay, 1: periodic

      // Counter only runs while staying in PRESSED; any exit or fresh entry
      // leaves it cleared so a bounce restarts the initial delay.
      always_comb begin
        rep_d    = '0;
        ph_d     = 1'b0;
        rep_fire = 1'b0;
        if (st_q == PRESSED && st_d == PRESSED) begin
          if (!ph_q) begin
            if (rep_q == RD_LAST) begin
              rep_fire = 1'b1;
              ph_d     = 1'b1;
            end else begin
              rep_d = rep_q + 1'b1;
            end
          end else begin
            ph_d = 1'b1;
            if (rep_q == RP_LAST) begin
              rep_fire = 1'b1;
            end else begin
              rep_d = rep_q + 1'b1;
            end
          end
        end
      end

      always_ff @(posedge clk or negedge async_reset) begin
        if (!async_reset) begin
          rep_q <= '0;
          ph_q  <= 1'b0;
        end else begin
          rep_q <= rep_d;
          ph_q  <= ph_d;
        end
      end
    end else begin : g_norep
      assign rep_fire = 1'b0;
    end
`else
    assign rep_fire = 1'b0;
`endif

    assign pulse[i]     = db_fire | rep_fire;
    assign btn_level[i] = lvl_q;
  end

  logic       pwr_q, inc_q, dec_q;
  logic [1:0] surf_q;

  always_ff @(posedge clk or negedge async_reset) begin
    if (!async_reset) begin
      pwr_q  <= 1'b0;
      surf_q <= '0;
      inc_q  <= 1'b0;
      dec_q  <= 1'b0;
    end else begin
      pwr_q  <= pulse[0];
      surf_q <= pulse[2:1];
      // Coinciding inc/dec requests cancel each other.
      inc_q  <= pulse[3] & ~pulse[4];
      dec_q  <= pulse[4] & ~pulse[3];
    end
  end

  assign power_toggle    = pwr_q;
  assign surface_toggle  = surf_q;
  assign power_level_inc = inc_q;
  assign power_level_dec = dec_q;

endmodule

// File: tb/tb_stove_button_conditioner.sv
module tb_stove_button_conditioner;

  logic       clk;
  logic       async_reset;
  logic [4:0] btn_raw;
  logic       power_toggle;
  logic [1:0] surface_toggle;
  logic       power_level_inc;
  logic       power_level_dec;
  logic [4:0] btn_level;

  stove_button_conditioner #(
    .DEBOUNCE_CYCLES  (4),
    .REPEAT_DELAY     (10),
    .REPEAT_PERIOD    (3),
    .BUTTON_ACTIVE_LOW(1)
  ) dut (
    .clk            (clk),
    .async_reset    (async_reset),
    .btn_raw        (btn_raw),
    .power_toggle   (power_toggle),
    .surface_toggle (surface_toggle),
    .power_level_inc(power_level_inc),
    .power_level_dec(power_level_dec),
    .btn_level      (btn_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared   = 0;
  int mismatched = 0;

  // Expected pulse: absolute edge count after which it is high, and vector
  // {dec, inc, surfB, surfA, power}.
  typedef struct {
    int unsigned cyc;
    logic [4:0]  vec;
  } exp_t;
  exp_t sb_q[$];

  function automatic void push(input int unsigned c, input logic [4:0] v);
    exp_t e;
    e.cyc = c;
    e.vec = v;
    sb_q.push_back(e);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: pops an expectation whenever a pulse is presented.
  always @(negedge clk) begin
    logic [4:0] v;
    exp_t e;
    v = {power_level_dec, power_level_inc, surface_toggle, power_toggle};
    while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
      e = sb_q.pop_front();
      compared++;
      mismatched++;
      $display("FAIL missed_pulse: got none expected %b at edge %0d (now %0d)", e.vec, e.cyc, cyc);
    end
    if (v != 5'b0) begin
      compared++;
      if (sb_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_pulse: got %b at edge %0d expected none", v, cyc);
      end else begin
        e = sb_q.pop_front();
        if (e.cyc != cyc || e.vec != v) begin
          mismatched++;
          $display("FAIL pulse: got %b at edge %0d expected %b at edge %0d", v, cyc, e.vec, e.cyc);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  int unsigned n;

  initial begin
    btn_raw     = '1;
    async_reset = 1'b0;
    #3;
    chk("rst_pulses", {27'b0, power_level_dec, power_level_inc, surface_toggle, power_toggle}, 0);
    chk("rst_level", {27'b0, btn_level}, 0);
    step(2);
    async_reset = 1'b1;
    step(3);

    // Clean press on power
    n = cyc;
    btn_raw[0] = 1'b0;
    push(n + 7, 5'b00001);
    step(6);
    chk("power_level_before", {31'b0, btn_level[0]}, 0);
    step(1);
    chk("power_level_after", {31'b0, btn_level[0]}, 1);
    step(13);
    btn_raw[0] = 1'b1;
    step(10);
    chk("power_released", {27'b0, btn_level}, 0);

    // Press glitch on surface A
    btn_raw[1] = 1'b0;
    step(3);
    btn_raw[1] = 1'b1;
    step(10);
    chk("glitch_level", {31'b0, btn_level[1]}, 0);

    // Surface A pressed, then a 2-cycle release bounce
    n = cyc;
    btn_raw[1] = 1'b0;
    push(n + 7, 5'b00010);
    step(10);
    btn_raw[1] = 1'b1;
    step(2);
    btn_raw[1] = 1'b0;
    step(10);
    chk("bounce_level", {31'b0, btn_level[1]}, 1);
    btn_raw[1] = 1'b1;
    step(10);
    chk("surfA_released", {31'b0, btn_level[1]}, 0);

    // Held inc
    n = cyc;
    btn_raw[3] = 1'b0;
    push(n + 7, 5'b01000);
`ifdef STOVE_BTN_AUTOREPEAT_EN
    push(n + 17, 5'b01000);
    push(n + 20, 5'b01000);
    push(n + 23, 5'b01000);
    push(n + 26, 5'b01000);
    push(n + 29, 5'b01000);
`endif
    step(28);
    btn_raw[3] = 1'b1;
    step(12);
    chk("inc_released", {31'b0, btn_level[3]}, 0);

    // inc and dec together: suppressed
    btn_raw[4:3] = 2'b00;
    step(8);
    chk("incdec_levels", {30'b0, btn_level[4:3]}, 2'b11);
    step(4);
    btn_raw[4:3] = 2'b11;
    step(10);

    // inc then dec two cycles later: both fire separately
    n = cyc;
    btn_raw[3] = 1'b0;
    push(n + 7, 5'b01000);
    push(n + 9, 5'b10000);
    step(2);
    btn_raw[4] = 1'b0;
    step(10);
    btn_raw[4:3] = 2'b11;
    step(10);

    // Surface A and B together
    n = cyc;
    btn_raw[2:1] = 2'b00;
    push(n + 7, 5'b00110);
    step(10);
    btn_raw[2:1] = 2'b11;
    step(10);

    // Reset while surface B held in PRESSED
    n = cyc;
    btn_raw[2] = 1'b0;
    push(n + 7, 5'b00100);
    step(10);
    chk("surfB_level_pre", {31'b0, btn_level[2]}, 1);
    async_reset = 1'b0;
    #1;
    chk("midrst_level", {27'b0, btn_level}, 0);
    chk("midrst_pulses", {27'b0, power_level_dec, power_level_inc, surface_toggle, power_toggle}, 0);
    step(1);
    n = cyc;
    async_reset = 1'b1;
    push(n + 7, 5'b00100);
    step(6);
    chk("postrst_level_before", {31'b0, btn_level[2]}, 0);
    step(1);
    chk("postrst_level_after", {31'b0, btn_level[2]}, 1);
    step(5);
    btn_raw[2] = 1'b1;
    step(12);

    chk("scoreboard_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
